// File: rtl/mem_write_responder.sv
// Memory-side write responder: one-entry posted-write buffer to the RAM port, LED register,
// read forwarding, write counter and sticky bad-write flag. Optional LED_READBACK_EN adds LED readback.
module mem_write_responder #(
  parameter int            DW       = 16,
  parameter int            AW       = 9,
  parameter logic [AW-1:0] LED_ADDR = 9'h100,
  parameter int            CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mem_cmd,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    write_data,
  output logic             ram_write,
  output logic [AW-2:0]    ram_waddr,
  output logic [DW-1:0]    ram_din,
  output logic             fwd_hit,
  output logic [DW-1:0]    fwd_data,
  output logic [7:0]       ledr,
  output logic [CNT_W-1:0] wr_count,
  output logic             bad_write
`ifdef LED_READBACK_EN
  ,
  output logic             led_rd_en,
  output logic [DW-1:0]    led_rd_data
`endif
);

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MRSVD  = 2'b11
  } cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t state;

  logic is_write;
  logic is_read;
  logic ram_sel;
  logic led_sel;
  logic ram_wr_req;

  assign is_write   = (mem_cmd == MWRITE);
  assign is_read    = (mem_cmd == MREAD);
  assign ram_sel    = ~mem_addr[AW-1];
  assign led_sel    = (mem_addr == LED_ADDR);
  assign ram_wr_req = is_write & ram_sel;

  // The RAM port registers double as the posted-write buffer: the entry is visible on the
  // port for exactly the cycle it drains, so forwarding compares against them directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ram_write <= 1'b0;
      ram_waddr <= '0;
      ram_din   <= '0;
      ledr      <= '0;
      wr_count  <= '0;
      bad_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_wr_req) begin
            state     <= PEND;
            ram_write <= 1'b1;
            ram_waddr <= mem_addr[AW-2:0];
            ram_din   <= write_data;
          end
        end
        PEND: begin
          if (ram_wr_req) begin
            state     <= PEND;
            ram_write <= 1'b1;
            ram_waddr <= mem_addr[AW-2:0];
            ram_din   <= write_data;
          end else begin
            state     <= IDLE;
            ram_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ram_write <= 1'b0;
        end
      endcase

      if (is_write && led_sel)
        ledr <= write_data[7:0];

      if (is_write && (ram_sel || led_sel))
        wr_count <= wr_count + CNT_W'(1);

      // Unmapped writes are dropped; only the sticky flag records them.
      if (is_write && !ram_sel && !led_sel)
        bad_write <= 1'b1;
    end
  end

  assign fwd_hit  = (state == PEND) & is_read & ram_sel & (mem_addr[AW-2:0] == ram_waddr);
  assign fwd_data = ram_din;

`ifdef LED_READBACK_EN
  assign led_rd_en   = is_read & led_sel;
  assign led_rd_data = {{(DW-8){1'b0}}, ledr};
`endif

endmodule

// File: tb/tb_mem_write_responder.sv
// Self-checking bench for mem_write_responder: directed vector table, wrap/reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_write_responder;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic        ram_write;
  logic [7:0]  ram_waddr;
  logic [15:0] ram_din;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [7:0]  ledr;
  logic [7:0]  wr_count;
  logic        bad_write;
`ifdef LED_READBACK_EN
  logic        led_rd_en;
  logic [15:0] led_rd_data;
`endif

  mem_write_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .ram_write  (ram_write),
    .ram_waddr  (ram_waddr),
    .ram_din    (ram_din),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .ledr       (ledr),
    .wr_count   (wr_count),
    .bad_write  (bad_write)
`ifdef LED_READBACK_EN
    ,
    .led_rd_en  (led_rd_en),
    .led_rd_data(led_rd_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] data;
    logic        fwd;
    logic [15:0] fwdd;
    logic        lrd;
    logic        rw;
    logic [7:0]  wa;
    logic [15:0] din;
    logic [7:0]  led;
    logic [7:0]  cnt;
    logic        bad;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, kept at the level of "what the last accepted write was"
  bit m_valid = 0;
  bit m_pend;
  int m_waddr;
  int m_din;
  int m_led;
  int m_cnt;
  bit m_bad;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void modelUpdate(bit rst, int cmd, int addr, int data);
    if (rst) begin
      m_valid = 1;
      m_pend  = 0;
      m_waddr = 0;
      m_din   = 0;
      m_led   = 0;
      m_cnt   = 0;
      m_bad   = 0;
    end else if (cmd == 2) begin
      if (addr < 256) begin
        m_pend  = 1;
        m_waddr = addr;
        m_din   = data;
        m_cnt   = (m_cnt + 1) % 256;
      end else if (addr == 256) begin
        m_pend = 0;
        m_led  = data % 256;
        m_cnt  = (m_cnt + 1) % 256;
      end else begin
        m_pend = 0;
        m_bad  = 1;
      end
    end else begin
      m_pend = 0;
    end
  endfunction

  // One clock cycle: drive, check combinational outputs mid-cycle, clock, check registered outputs.
  task automatic applyStimulus(input vec_t v, input bit use_tbl);
    bit exp_fwd;
    reset      = v.rst;
    mem_cmd    = v.cmd;
    mem_addr   = v.addr;
    write_data = v.data;
    #3;
    if (m_valid) begin
      exp_fwd = m_pend && v.cmd == C_READ && int'(v.addr) < 256 && int'(v.addr) == m_waddr;
      checkOutput("fwd_hit", 32'(fwd_hit), 32'(exp_fwd));
      if (exp_fwd) checkOutput("fwd_data", 32'(fwd_data), 32'(m_din));
`ifdef LED_READBACK_EN
      checkOutput("led_rd_en", 32'(led_rd_en), 32'(v.cmd == C_READ && v.addr == 9'h100));
      checkOutput("led_rd_data", 32'(led_rd_data), 32'(m_led));
`endif
    end
    if (use_tbl && m_valid) begin
      checkOutput("tbl_fwd_hit", 32'(fwd_hit), 32'(v.fwd));
      if (v.fwd) checkOutput("tbl_fwd_data", 32'(fwd_data), 32'(v.fwdd));
`ifdef LED_READBACK_EN
      checkOutput("tbl_led_rd_en", 32'(led_rd_en), 32'(v.lrd));
`endif
    end
    @(posedge clk);
    modelUpdate(v.rst, int'(v.cmd), int'(v.addr), int'(v.data));
    #1;
    checkOutput("ram_write", 32'(ram_write), 32'(m_pend));
    checkOutput("ram_waddr", 32'(ram_waddr), 32'(m_waddr));
    checkOutput("ram_din", 32'(ram_din), 32'(m_din));
    checkOutput("ledr", 32'(ledr), 32'(m_led));
    checkOutput("wr_count", 32'(wr_count), 32'(m_cnt));
    checkOutput("bad_write", 32'(bad_write), 32'(m_bad));
    if (use_tbl) begin
      checkOutput("tbl_ram_write", 32'(ram_write), 32'(v.rw));
      checkOutput("tbl_ram_waddr", 32'(ram_waddr), 32'(v.wa));
      checkOutput("tbl_ram_din", 32'(ram_din), 32'(v.din));
      checkOutput("tbl_ledr", 32'(ledr), 32'(v.led));
      checkOutput("tbl_wr_count", 32'(wr_count), 32'(v.cnt));
      checkOutput("tbl_bad_write", 32'(bad_write), 32'(v.bad));
    end
  endtask

  task automatic drive(input bit rst, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] data);
    vec_t v;
    v = '{rst, cmd, addr, data, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 8'h0, 8'h0, 1'b0};
    applyStimulus(v, 1'b0);
  endtask

  vec_t tbl[17];

  initial begin
    reset      = 1'b1;
    mem_cmd    = C_NONE;
    mem_addr   = '0;
    write_data = '0;

    //            rst  cmd      addr     data      fwd   fwdd      lrd   rw    wa      din       led     cnt    bad
    tbl[0]  = '{1'b1, C_WRITE, 9'h005, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, C_WRITE, 9'h005, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, C_WRITE, 9'h005, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h05, 16'hBEEF, 8'h00, 8'd1, 1'b0};
    tbl[3]  = '{1'b0, C_NONE,  9'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h05, 16'hBEEF, 8'h00, 8'd1, 1'b0};
    tbl[4]  = '{1'b0, C_WRITE, 9'h010, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h10, 16'h1111, 8'h00, 8'd2, 1'b0};
    tbl[5]  = '{1'b0, C_WRITE, 9'h011, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h11, 16'h2222, 8'h00, 8'd3, 1'b0};
    tbl[6]  = '{1'b0, C_NONE,  9'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h11, 16'h2222, 8'h00, 8'd3, 1'b0};
    tbl[7]  = '{1'b0, C_WRITE, 9'h020, 16'hCAFE, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h20, 16'hCAFE, 8'h00, 8'd4, 1'b0};
    tbl[8]  = '{1'b0, C_READ,  9'h020, 16'h0000, 1'b1, 16'hCAFE, 1'b0, 1'b0, 8'h20, 16'hCAFE, 8'h00, 8'd4, 1'b0};
    tbl[9]  = '{1'b0, C_WRITE, 9'h020, 16'hCAFE, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h20, 16'hCAFE, 8'h00, 8'd5, 1'b0};
    tbl[10] = '{1'b0, C_READ,  9'h021, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h20, 16'hCAFE, 8'h00, 8'd5, 1'b0};
    tbl[11] = '{1'b0, C_WRITE, 9'h100, 16'hAB5A, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h20, 16'hCAFE, 8'h5A, 8'd6, 1'b0};
    tbl[12] = '{1'b0, C_WRITE, 9'h1F0, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h20, 16'hCAFE, 8'h5A, 8'd6, 1'b1};
    tbl[13] = '{1'b0, C_READ,  9'h100, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h20, 16'hCAFE, 8'h5A, 8'd6, 1'b1};
    tbl[14] = '{1'b0, C_RSVD,  9'h07F, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h20, 16'hCAFE, 8'h5A, 8'd6, 1'b1};
    tbl[15] = '{1'b0, C_WRITE, 9'h07F, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h7F, 16'h0001, 8'h5A, 8'd7, 1'b1};
    tbl[16] = '{1'b1, C_NONE,  9'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 8'd0, 1'b0};

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) applyStimulus(tbl[i], 1'b1);

    $display("[TB] wr_count wrap over 256 RAM writes");
    drive(1'b1, C_NONE, 9'h000, 16'h0000);
    for (int i = 0; i < 256; i++)
      drive(1'b0, C_WRITE, 9'(i), 16'($urandom));
    checkOutput("wrap_count", 32'(wr_count), 32'd0);

    $display("[TB] reset while a write is pending");
    drive(1'b0, C_WRITE, 9'h033, 16'h5555);
    checkOutput("pend_before_reset", 32'(ram_write), 32'd1);
    drive(1'b1, C_WRITE, 9'h044, 16'h6666);
    checkOutput("reset_drops_pend", 32'(ram_write), 32'd0);
    drive(1'b0, C_NONE, 9'h000, 16'h0000);
    checkOutput("no_late_write", 32'(ram_write), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  cmd;
      logic [8:0]  addr;
      int          sel;
      cmd = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      addr = 9'($urandom_range(0, 7));
      else if (sel == 6) addr = 9'h100;
      else if (sel == 7) addr = 9'h100 | 9'($urandom_range(0, 255));
      else               addr = 9'(m_waddr);
      drive($urandom_range(0, 39) == 0, cmd, addr, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
